// File: rtl/regfile_pkg.sv
// Shared widths and write-back request type for the register-file write-back path.
package regfile_pkg;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);
  localparam int DW    = 32;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, combinational from valids and last_grant; no grants while in reset.
// last_grant moves only on an accepted handshake, so a waiting requester keeps its priority.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);
  // last_grant_q == 1 means requester 1 won last, so requester 0 wins the next contention.
  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) last_grant_d = grant[1];
  end

  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the RegisterFile write port between ALU and load write-back; WE3 follows acceptance by 1 cycle.
// Readies are round-robin grants (forced low in reset); also keeps the pending scoreboard and read hazards.
module regfile_wb_arbiter #(
  parameter int NREGS = regfile_pkg::NREGS,
  parameter int AW    = regfile_pkg::AW,
  parameter int DW    = regfile_pkg::DW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [AW-1:0]    req0_addr,
  input  logic [DW-1:0]    req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [AW-1:0]    req1_addr,
  input  logic [DW-1:0]    req1_data,
  input  logic             rsv_valid,
  input  logic [AW-1:0]    rsv_addr,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic             hazard1,
  output logic             hazard2,
  output logic             WE3,
  output logic [AW-1:0]    A3,
  output logic [DW-1:0]    WD3,
  output logic [NREGS-1:0] pending
);
  logic [1:0]           grant;
  logic                 accept;
  regfile_pkg::wb_req_t acc_req;

  logic             we3_q, we3_d;
  logic [AW-1:0]    a3_q, a3_d;
  logic [DW-1:0]    wd3_q, wd3_d;
  logic [NREGS-1:0] pending_q, pending_d;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid  ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  always_comb begin
    acc_req.addr = req0_addr;
    acc_req.data = req0_data;
    if (grant[1]) begin
      acc_req.addr = req1_addr;
      acc_req.data = req1_data;
    end
  end

  // x0 writes complete the handshake but never reach the file or the scoreboard.
  always_comb begin
    we3_d     = accept && (acc_req.addr != '0);
    a3_d      = a3_q;
    wd3_d     = wd3_q;
    pending_d = pending_q;
    if (we3_d) begin
      a3_d                    = acc_req.addr;
      wd3_d                   = acc_req.data;
      pending_d[acc_req.addr] = 1'b0;
    end
    // Applied after the clear so a newly issued producer of the same register wins.
    if (rsv_valid && (rsv_addr != '0)) pending_d[rsv_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we3_q     <= 1'b0;
      a3_q      <= '0;
      wd3_q     <= '0;
      pending_q <= '0;
    end else begin
      we3_q     <= we3_d;
      a3_q      <= a3_d;
      wd3_q     <= wd3_d;
      pending_q <= pending_d;
    end
  end

  // The in-flight term covers the cycle where the file has not yet committed WD3.
  assign hazard1 = (rd_addr1 != '0) && (pending_q[rd_addr1] || (we3_q && (a3_q == rd_addr1)));
  assign hazard2 = (rd_addr2 != '0) && (pending_q[rd_addr2] || (we3_q && (a3_q == rd_addr2)));

  assign WE3     = we3_q;
  assign A3      = a3_q;
  assign WD3     = wd3_q;
  assign pending = pending_q;
endmodule
